// File: rtl/audio_pkg.sv
// audio_pkg: shared definitions for the record/playback controller.
//   - default SRAM address / sample widths
//   - 2-bit controller state encoding (IDLE/RECORD/PLAY/PAUSE)
//   - SRAM access type (RD/WR)
package audio_pkg;

    localparam int DEF_ADDR_W = 18;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        PLAY   = 2'd2,
        PAUSE  = 2'd3
    } state_t;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } acc_t;

endpackage

// File: rtl/audio_if.sv
// audio_if: one-sample handshake between the ADC/DAC serializers and the
// controller.
//   master (serializer side): drives wr_req/wr_data/rd_req, receives
//                             wr_ack/rd_data/rd_valid
//   slave  (audio_ctrl side): the mirror image
interface audio_if
    import audio_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              wr_req;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              rd_req;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output wr_req, wr_data, rd_req,
        input  wr_ack, rd_data, rd_valid
    );

    modport slave (
        input  wr_req, wr_data, rd_req,
        output wr_ack, rd_data, rd_valid
    );

endinterface

// File: rtl/sram_seq.sv
// sram_seq: single-port SRAM access sequencer.
// Runs one access at a time: strobes low for 1+SRAM_WAIT cycles, then one
// cycle with all strobes high before the next access. Holds a one-deep
// pending slot; a request that finds the slot full is dropped and reported
// on drop. abort kills the in-flight access and the pending slot without any
// ack/valid.
// Ports: clk, rst (async, active-high), abort, req/req_type/req_data/req_addr
// (request in; req_addr is sampled when the access starts), ack/valid/drop
// (one-cycle pulses), rd_data (held), sram_* pins (all registered).
module sram_seq
    import audio_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int SRAM_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              abort,
    input  logic              req,
    input  acc_t              req_type,
    input  logic [DATA_W-1:0] req_data,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              ack,
    output logic              valid,
    output logic              drop,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_o,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    logic              acc_r;
    acc_t              acc_type_r;
    logic [2:0]        cnt_r;
    logic              pend_r;
    acc_t              pend_type_r;
    logic [DATA_W-1:0] pend_data_r;

    logic              start_s;
    logic              direct_s;
    acc_t              start_type_s;
    logic [DATA_W-1:0] start_data_s;

    // Pick what starts next: the pending slot always goes before a new request.
    always_comb begin
        start_s  = !acc_r && (pend_r || req);
        direct_s = start_s && !pend_r;
        if (pend_r) begin
            start_type_s = pend_type_r;
            start_data_s = pend_data_r;
        end else begin
            start_type_s = req_type;
            start_data_s = req_data;
        end
    end

    // Strobe timing, wait counter, pending slot and read capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r       <= 1'b0;
            acc_type_r  <= RD;
            cnt_r       <= 3'd0;
            pend_r      <= 1'b0;
            pend_type_r <= RD;
            pend_data_r <= {DATA_W{1'b0}};
            ack         <= 1'b0;
            valid       <= 1'b0;
            drop        <= 1'b0;
            rd_data     <= {DATA_W{1'b0}};
            sram_addr   <= {ADDR_W{1'b0}};
            sram_dq_o   <= {DATA_W{1'b0}};
            sram_dq_oe  <= 1'b0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
        end else if (abort) begin
            acc_r      <= 1'b0;
            pend_r     <= 1'b0;
            ack        <= 1'b0;
            valid      <= 1'b0;
            drop       <= 1'b0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
        end else begin
            ack   <= 1'b0;
            valid <= 1'b0;
            drop  <= 1'b0;
            if (acc_r) begin
                if (cnt_r == 3'd0) begin
                    // Last strobe cycle: release the bus and report completion.
                    acc_r      <= 1'b0;
                    sram_dq_oe <= 1'b0;
                    sram_ce_n  <= 1'b1;
                    sram_oe_n  <= 1'b1;
                    sram_we_n  <= 1'b1;
                    if (acc_type_r == WR) begin
                        ack <= 1'b1;
                    end else begin
                        valid   <= 1'b1;
                        rd_data <= sram_dq_i;
                    end
                end else begin
                    cnt_r <= cnt_r - 3'd1;
                end
            end else if (start_s) begin
                acc_r      <= 1'b1;
                acc_type_r <= start_type_s;
                cnt_r      <= 3'(SRAM_WAIT);
                sram_addr  <= req_addr;
                sram_dq_o  <= start_data_s;
                sram_ce_n  <= 1'b0;
                sram_we_n  <= (start_type_s != WR);
                sram_oe_n  <= (start_type_s != RD);
                sram_dq_oe <= (start_type_s == WR);
            end

            // The slot counts as free if it is being emptied at this edge.
            if (req && !direct_s) begin
                if (!pend_r || start_s) begin
                    pend_r      <= 1'b1;
                    pend_type_r <= req_type;
                    pend_data_r <= req_data;
                end else begin
                    drop <= 1'b1;
                end
            end else if (start_s) begin
                pend_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/audio_ctrl.sv
// audio_ctrl: record/playback controller owning the external 16-bit SRAM.
// Holds the mode FSM (IDLE/RECORD/PLAY/PAUSE), the access/length counters and
// command decode; SRAM strobe timing lives in sram_seq.
// Ports: clk, rst (async, active-high); cmd_rec/play/pause/stop pulses;
// rec_en/play_en serializer enables; bus (audio_if.slave sample handshake);
// sram_* pins; state, cur_addr, end_addr, overrun status.
// Build option: define AUDIO_LOOP_EN to make PLAY wrap to address 0 after the
// last recorded word instead of stopping.
module audio_ctrl
    import audio_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int SRAM_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_rec,
    input  logic              cmd_play,
    input  logic              cmd_pause,
    input  logic              cmd_stop,
    output logic              rec_en,
    output logic              play_en,
    audio_if.slave            bus,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_o,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [1:0]        state,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [ADDR_W-1:0] end_addr,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
`ifdef AUDIO_LOOP_EN
    localparam logic LOOP_EN = 1'b1;
`else
    localparam logic LOOP_EN = 1'b0;
`endif

    state_t            state_r;
    state_t            resume_r;
    logic [ADDR_W-1:0] cur_addr_r;
    logic [ADDR_W-1:0] end_addr_r;
    logic              overrun_r;
    logic              rec_en_r;
    logic              play_en_r;

    logic              ack_s, valid_s, drop_s, done_s;
    logic [DATA_W-1:0] rd_data_s;
    logic [ADDR_W-1:0] addr_inc_s, nxt_addr_s, seq_addr_s;
    logic              last_rd_s, last_wr_s, auto_stop_s;
    logic              stop_s, go_rec_s, go_play_s, go_pause_s;
    logic              abort_s, req_s;
    acc_t              req_type_s;

    assign done_s = ack_s | valid_s;

    // Address stepping, end-of-buffer detection and command decode.
    always_comb begin
        addr_inc_s = cur_addr_r + ADDR_ONE;
        last_rd_s  = (state_r == PLAY) && (addr_inc_s == end_addr_r);
        last_wr_s  = (state_r == RECORD) && (cur_addr_r == ADDR_MAX);
        if (last_rd_s && LOOP_EN) begin
            nxt_addr_s = {ADDR_W{1'b0}};
        end else begin
            nxt_addr_s = addr_inc_s;
        end
        auto_stop_s = done_s && (last_wr_s || (last_rd_s && !LOOP_EN));
        // A pending access starts on the same edge that retires the previous
        // one, so it must already see the advanced address.
        seq_addr_s = done_s ? nxt_addr_s : cur_addr_r;

        // Priority stop > rec > play > pause; a raised higher command masks
        // the lower ones even when it has no effect in the current state.
        go_rec_s   = 1'b0;
        go_play_s  = 1'b0;
        go_pause_s = 1'b0;
        if (!cmd_stop) begin
            if (cmd_rec) begin
                go_rec_s = (state_r != RECORD);
            end else if (cmd_play) begin
                go_play_s = (state_r != PLAY) && (end_addr_r != {ADDR_W{1'b0}});
            end else if (cmd_pause) begin
                go_pause_s = (state_r != IDLE);
            end else begin
                go_pause_s = 1'b0;
            end
        end else begin
            go_rec_s = 1'b0;
        end
        stop_s = cmd_stop || (auto_stop_s && !go_rec_s && !go_play_s);
        // Any mode change (pause included) abandons the in-flight access.
        abort_s = stop_s || go_rec_s || go_play_s || go_pause_s;

        req_s      = ((state_r == RECORD) && bus.wr_req) || ((state_r == PLAY) && bus.rd_req);
        req_type_s = (state_r == RECORD) ? WR : RD;
    end

    // Mode FSM with address/length counters and registered enables.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            resume_r   <= RECORD;
            cur_addr_r <= {ADDR_W{1'b0}};
            end_addr_r <= {ADDR_W{1'b0}};
            overrun_r  <= 1'b0;
            rec_en_r   <= 1'b0;
            play_en_r  <= 1'b0;
        end else begin
            if (done_s) begin
                cur_addr_r <= nxt_addr_s;
                if (state_r == RECORD) begin
                    end_addr_r <= last_wr_s ? ADDR_MAX : addr_inc_s;
                end
            end
            if (drop_s) begin
                overrun_r <= 1'b1;
            end

            if (stop_s) begin
                state_r    <= IDLE;
                rec_en_r   <= 1'b0;
                play_en_r  <= 1'b0;
                cur_addr_r <= {ADDR_W{1'b0}};
            end else if (go_rec_s) begin
                state_r    <= RECORD;
                rec_en_r   <= 1'b1;
                play_en_r  <= 1'b0;
                cur_addr_r <= {ADDR_W{1'b0}};
                end_addr_r <= {ADDR_W{1'b0}};
                overrun_r  <= 1'b0;
            end else if (go_play_s) begin
                state_r    <= PLAY;
                rec_en_r   <= 1'b0;
                play_en_r  <= 1'b1;
                cur_addr_r <= {ADDR_W{1'b0}};
                overrun_r  <= 1'b0;
            end else if (go_pause_s) begin
                case (state_r)
                    RECORD, PLAY: begin
                        resume_r  <= state_r;
                        state_r   <= PAUSE;
                        rec_en_r  <= 1'b0;
                        play_en_r <= 1'b0;
                    end
                    PAUSE: begin
                        state_r   <= resume_r;
                        rec_en_r  <= (resume_r == RECORD);
                        play_en_r <= (resume_r == PLAY);
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    sram_seq #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .SRAM_WAIT (SRAM_WAIT)
    ) u_seq (
        .clk        (clk),
        .rst        (rst),
        .abort      (abort_s),
        .req        (req_s),
        .req_type   (req_type_s),
        .req_data   (bus.wr_data),
        .req_addr   (seq_addr_s),
        .ack        (ack_s),
        .valid      (valid_s),
        .drop       (drop_s),
        .rd_data    (rd_data_s),
        .sram_addr  (sram_addr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_i  (sram_dq_i),
        .sram_dq_oe (sram_dq_oe),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n)
    );

    assign bus.wr_ack   = ack_s;
    assign bus.rd_valid = valid_s;
    assign bus.rd_data  = rd_data_s;
    assign state        = state_r;
    assign cur_addr     = cur_addr_r;
    assign end_addr     = end_addr_r;
    assign overrun      = overrun_r;
    assign rec_en       = rec_en_r;
    assign play_en      = play_en_r;

endmodule

// File: doc/audio_ctrl.md
# audio_ctrl

Record/playback controller for the codec audio path. It owns the single external 16-bit SRAM, sequences record, play and pause modes, and enables the ADC deserializer and DAC serializer. It serves one-sample read/write handshakes from them and tracks the recorded length. The block sits between the key/debounce logic and the SRAM pins, and is the only driver of the SRAM address bus.

## Interface
- ADDR_W, 18, SRAM word-address width
- DATA_W, 16, sample width
- SRAM_WAIT, 1, extra cycles each SRAM strobe is held (0..7)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cmd_rec, cmd_play, cmd_pause, cmd_stop  in  1 each  debounced one-cycle command pulses
- rec_en  out  1  enables ADC deserializer
- play_en  out  1  enables DAC serializer
- wr_req  in  1  one-cycle pulse; wr_data valid
- wr_data  in  DATA_W  sample to store
- wr_ack  out  1  one-cycle pulse; write done
- rd_req  in  1  one-cycle pulse; next sample wanted
- rd_data  out  DATA_W  sample read; held until next rd_valid
- rd_valid  out  1  one-cycle pulse; rd_data updated
- sram_addr  out  ADDR_W  SRAM address
- sram_dq_o  out  DATA_W  write data
- sram_dq_i  in  DATA_W  read data
- sram_dq_oe  out  1  drive data pins
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM strobes, active-low
- state  out  2  IDLE=0, RECORD=1, PLAY=2, PAUSE=3
- cur_addr  out  ADDR_W  next access address
- end_addr  out  ADDR_W  recorded length in words
- overrun  out  1  sticky; a request was dropped

## Operation
- Reset values:
  - state=IDLE; cur_addr=0; end_addr=0.
  - rec_en=play_en=wr_ack=rd_valid=overrun=0; rd_data=0; sram_addr=0; sram_dq_o=0; sram_dq_oe=0.
  - All sram_*_n=1.
- Command priority within one cycle: stop > rec > play > pause.
- IDLE:
  - cmd_rec → RECORD; cur_addr=0, end_addr=0, overrun cleared.
  - cmd_play with end_addr≠0 → PLAY; cur_addr=0, overrun cleared.
  - cmd_play with end_addr=0 is ignored.
- RECORD:
  - Each wr_req writes wr_data at cur_addr; on completion cur_addr+1 and end_addr=cur_addr+1.
  - A write completing at address 2^ADDR_W−1 → IDLE automatically; end_addr saturates at 2^ADDR_W−1.
- PLAY:
  - Each rd_req reads cur_addr; cur_addr+1 on completion.
  - The read that completes at end_addr−1 → IDLE.
- PAUSE:
  - cmd_pause in RECORD/PLAY → PAUSE; the mode is remembered.
  - cmd_pause in PAUSE → the remembered mode, with cur_addr unchanged.
- cmd_stop in any state → IDLE next cycle:
  - An in-flight access is aborted: strobes return high and no ack/valid is issued.
  - cur_addr resets to 0; end_addr is kept.
- Mode filtering: rec_en=1 only in RECORD; play_en=1 only in PLAY. Requests in any other state are ignored with no ack and no overrun.
- The sequencer serves one access at a time and has a one-deep pending slot. A request arriving while the slot is full is dropped and sets overrun.
- cmd_rec during PLAY or PAUSE (and likewise cmd_play) takes effect as from IDLE: the access is aborted, then the new mode starts.

## Timing
- Request at cycle t with the sequencer idle:
  - sram_addr is valid and sram_ce_n is low from t+1.
  - sram_we_n (with sram_dq_oe) or sram_oe_n is low for cycles t+1 .. t+1+SRAM_WAIT.
- Read: sram_dq_i is sampled at the end of cycle t+1+SRAM_WAIT; rd_valid and the new rd_data appear at t+2+SRAM_WAIT (t+3 for default).
- Write: wr_ack at t+2+SRAM_WAIT; sram_dq_oe deasserts in the same cycle as sram_we_n rises.
- A pending request starts in the cycle after the previous access ends. One idle strobe cycle always separates accesses.
- A state change caused by a command is visible on state/rec_en/play_en one cycle after the pulse.
- Auto-stop is visible one cycle after the final ack/valid.

## Configuration
- AUDIO_LOOP_EN defined: PLAY does not auto-stop. After the read at end_addr−1, cur_addr wraps to 0 and play continues until cmd_stop or cmd_pause.
- AUDIO_LOOP_EN undefined: auto-stop to IDLE as in Operation.

## Structure
- Shared package audio_pkg:
  - 2-bit state encoding constants IDLE/RECORD/PLAY/PAUSE
  - default ADDR_W/DATA_W
  - access-type constants RD/WR
- Sub-module sram_seq holds the strobe timing, wait counter, pending slot and read capture. audio_ctrl holds the mode FSM, address/length counters and command decode.

## Test plan
- Reset mid-write (sram_we_n low), rst=1 → all outputs at reset values in the same cycle, state=IDLE.
- IDLE, cmd_rec, 4 wr_req spaced 5 cycles with data 0x1111..0x4444 → wr_ack at t+3 each, SRAM words 0..3 written, end_addr=4; cmd_stop → IDLE.
- Then cmd_play, 4 rd_req → rd_valid at t+3, rd_data 0x1111..0x4444. Auto-stop → IDLE with play_en=0. With AUDIO_LOOP_EN, a 5th read returns 0x1111.
- RECORD, three wr_req on consecutive cycles → first two served back-to-back, third dropped, overrun=1, cur_addr=2.
- PLAY at cur_addr=2, cmd_pause → PAUSE with play_en=0 and rd_req ignored. cmd_pause again → PLAY, next read address 2.
- Same cycle cmd_stop and cmd_rec during a read → IDLE with no rd_valid. cmd_play in IDLE with end_addr=0 → stays IDLE.
